// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory store buffer.
// The entry layout matches the default 32-bit core; word addresses drop the byte offset.
package dmem_pkg;

    localparam int SB_DEPTH_DEFAULT = 4;
    localparam int SB_AW            = 32;
    localparam int SB_DW            = 32;

    typedef struct packed {
        logic [SB_AW-3:0] waddr;
        logic [SB_DW-1:0] wdata;
    } sb_entry_t;

    function automatic logic [SB_AW-3:0] word_addr(input logic [SB_AW-1:0] addr);
        return addr[SB_AW-1:2];
    endfunction

endpackage

// File: rtl/dmem_store_buffer_if.sv
// Core-side load/store port and memory-side write/read port of the store buffer.
// master drives requests; slave answers them (core->buffer, buffer->memory).
interface dmem_core_if #(
    parameter int AW = 32,
    parameter int DW = 32
) ();
    logic          memwrite;
    logic          memread;
    logic [AW-1:0] aluout;
    logic [DW-1:0] writedata;
    logic [DW-1:0] readdata;
    logic          stall;

    modport master (
        output memwrite, memread, aluout, writedata,
        input  readdata, stall
    );

    modport slave (
        input  memwrite, memread, aluout, writedata,
        output readdata, stall
    );
endinterface

interface dmem_mem_if #(
    parameter int AW = 32,
    parameter int DW = 32
) ();
    logic          mem_wvalid;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;
    logic          mem_wready;
    logic [AW-1:0] mem_raddr;
    logic [DW-1:0] mem_rdata;

    modport master (
        output mem_wvalid, mem_waddr, mem_wdata, mem_raddr,
        input  mem_wready, mem_rdata
    );

    modport slave (
        input  mem_wvalid, mem_waddr, mem_wdata, mem_raddr,
        output mem_wready, mem_rdata
    );
endinterface

// File: rtl/sb_fifo.sv
// Circular buffer with head/tail/count; exposes every slot and its valid bit for searching.
// Push lands next edge; a push while full is taken only together with a pop.
module sb_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 62,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      push_i,
    input  logic [W-1:0]              push_dat_i,
    input  logic                      pop_i,
    output logic [W-1:0]              head_dat_o,
    output logic [PW-1:0]             head_o,
    output logic [DEPTH-1:0][W-1:0]   entries_o,
    output logic [DEPTH-1:0]          valid_o,
    output logic                      full_o,
    output logic                      empty_o
);

    logic [DEPTH-1:0][W-1:0] mem_q;
    logic [PW-1:0]           head_q, head_d;
    logic [PW-1:0]           tail_q, tail_d;
    logic [CW-1:0]           count_q, count_d;
    logic                    do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);

    // When full, tail equals head, so a push paired with a pop reuses the slot being freed.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q + CW'(do_push) - CW'(do_pop);
        if (do_push) tail_d = tail_q + 1'b1;
        if (do_pop)  head_d = head_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[tail_q] <= push_dat_i;
    end

    always_comb begin
        valid_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            valid_o[i] = ({1'b0, PW'(i) - head_q} < count_q);
        end
    end

    assign head_dat_o = mem_q[head_q];
    assign head_o     = head_q;
    assign entries_o  = mem_q;

endmodule

// File: rtl/dmem_store_buffer.sv
// Posted-write buffer between the core data port and memory, with store-to-load forwarding.
// Store to mem_wvalid is 1 cycle from empty; the core stalls only on a store into a full buffer with no pop.
module dmem_store_buffer
    import dmem_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH_DEFAULT,
    parameter int AW    = SB_AW,
    parameter int DW    = SB_DW
) (
    input  logic            clk,
    input  logic            reset,
    dmem_core_if.slave      core,
    dmem_mem_if.master      mem,
    output logic            empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int EW = $bits(sb_entry_t);

    logic                     push, pop;
    logic                     fifo_full, fifo_empty;
    sb_entry_t                push_ent, head_ent;
    logic [EW-1:0]            head_raw;
    logic [PW-1:0]            head_idx;
    logic [DEPTH-1:0][EW-1:0] ents;
    logic [DEPTH-1:0]         ents_vld;
    logic [DW-1:0]            fwd_dat;

    assign push_ent.waddr = word_addr(core.aluout);
    assign push_ent.wdata = core.writedata;

    sb_fifo #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push_i     (push),
        .push_dat_i (push_ent),
        .pop_i      (pop),
        .head_dat_o (head_raw),
        .head_o     (head_idx),
        .entries_o  (ents),
        .valid_o    (ents_vld),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    assign head_ent = sb_entry_t'(head_raw);

    // Drain side: head entry is presented until memory accepts it.
    assign mem.mem_wvalid = !fifo_empty;
    assign mem.mem_waddr  = fifo_empty ? '0 : {head_ent.waddr, 2'b00};
    assign mem.mem_wdata  = fifo_empty ? '0 : head_ent.wdata;
    assign pop            = mem.mem_wvalid && mem.mem_wready;

    // A pop in the same cycle frees the slot, so a full buffer only stalls without one.
    assign core.stall = core.memwrite && fifo_full && !pop;
    assign push       = core.memwrite && !core.stall;

    assign empty         = fifo_empty;
    assign mem.mem_raddr = {core.aluout[AW-1:2], 2'b00};

    // Walk oldest to youngest so the youngest matching store wins.
    always_comb begin
        logic [PW-1:0] idx;
        sb_entry_t     e;
        idx     = '0;
        e       = '0;
        fwd_dat = mem.mem_rdata;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_idx + PW'(k);
            e   = sb_entry_t'(ents[idx]);
            if (ents_vld[idx] && (e.waddr == word_addr(core.aluout))) fwd_dat = e.wdata;
        end
    end

    assign core.readdata = core.memread ? fwd_dat : mem.mem_rdata;

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Directed bench for dmem_store_buffer: expected memory writes go into a queue,
// a negedge monitor checks every accepted write against it.
module tb_dmem_store_buffer;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic empty;

    dmem_core_if core_if ();
    dmem_mem_if  mem_if ();

    dmem_store_buffer #(
        .DEPTH (4),
        .AW    (32),
        .DW    (32)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .core  (core_if),
        .mem   (mem_if),
        .empty (empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    wr_t exp_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input bit expect_it);
        core_if.memwrite  = 1'b1;
        core_if.aluout    = a;
        core_if.writedata = d;
        if (expect_it) exp_q.push_back('{a, d});
    endtask

    // Monitor: every accepted write must be the oldest outstanding expected write.
    always @(negedge clk) begin
        wr_t w;
        if (reset && mem_if.mem_wvalid && mem_if.mem_wready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h, expected no write",
                         mem_if.mem_waddr, mem_if.mem_wdata);
            end else begin
                w = exp_q.pop_front();
                chk("drain_addr", mem_if.mem_waddr, w.a & ~32'h3);
                chk("drain_data", mem_if.mem_wdata, w.d);
            end
        end
    end

    initial begin
        core_if.memwrite  = 1'b0;
        core_if.memread   = 1'b0;
        core_if.aluout    = '0;
        core_if.writedata = '0;
        mem_if.mem_wready = 1'b0;
        mem_if.mem_rdata  = '0;

        // Reset and empty
        #22 reset = 1'b1;
        #1;
        chk("rst_empty",  {31'b0, empty}, 32'd1);
        chk("rst_wvalid", {31'b0, mem_if.mem_wvalid}, 32'd0);
        chk("rst_stall",  {31'b0, core_if.stall}, 32'd0);
        chk("rst_waddr",  mem_if.mem_waddr, 32'h0);
        chk("rst_wdata",  mem_if.mem_wdata, 32'h0);
        core_if.memread  = 1'b1;
        core_if.aluout   = 32'h54;
        mem_if.mem_rdata = 32'hDEADBEEF;
        #1;
        chk("rst_load", core_if.readdata, 32'hDEADBEEF);
        chk("raddr", mem_if.mem_raddr, 32'h54);
        core_if.memread = 1'b0;
        step();

        // Single store with memory ready
        mem_if.mem_wready = 1'b1;
        store(32'h54, 32'd7, 1'b1);
        step();
        core_if.memwrite = 1'b0;
        chk("single_wvalid", {31'b0, mem_if.mem_wvalid}, 32'd1);
        chk("single_waddr",  mem_if.mem_waddr, 32'h54);
        chk("single_wdata",  mem_if.mem_wdata, 32'd7);
        step();
        chk("single_empty", {31'b0, empty}, 32'd1);

        // Backpressure to full, then release in the stalled cycle
        mem_if.mem_wready = 1'b0;
        store(32'h18, 32'hA1, 1'b1); step();
        store(32'h1C, 32'hA2, 1'b1); step();
        store(32'h20, 32'hA3, 1'b1); step();
        store(32'h34, 32'hA4, 1'b1); step();
        store(32'h14, 32'hA5, 1'b1);
        #1;
        chk("full_stall", {31'b0, core_if.stall}, 32'd1);
        mem_if.mem_wready = 1'b1;
        #1;
        chk("full_release_stall", {31'b0, core_if.stall}, 32'd0);
        step();
        core_if.memwrite = 1'b0;
        repeat (6) step();
        chk("full_drained", {31'b0, empty}, 32'd1);

        // Forwarding picks the youngest matching store
        mem_if.mem_wready = 1'b0;
        store(32'h20, 32'd5, 1'b1);  step();
        store(32'h20, 32'd28, 1'b1); step();
        core_if.memwrite = 1'b0;
        core_if.memread  = 1'b1;
        core_if.aluout   = 32'h20;
        mem_if.mem_rdata = 32'hAAAA5555;
        #1;
        chk("fwd_youngest", core_if.readdata, 32'd28);
        core_if.aluout = 32'h24;
        #1;
        chk("fwd_miss", core_if.readdata, 32'hAAAA5555);
        core_if.aluout = 32'h23;
        #1;
        chk("fwd_byte_ofs", core_if.readdata, 32'd28);
        chk("raddr_align",  mem_if.mem_raddr, 32'h20);
        core_if.memread   = 1'b0;
        mem_if.mem_wready = 1'b1;
        repeat (4) step();
        chk("fwd_drained", {31'b0, empty}, 32'd1);

        // Push and pop together at full over three laps of the ring
        mem_if.mem_wready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            store(32'h80 + 32'(4 * i), 32'h80 + 32'(i), 1'b1);
            step();
        end
        mem_if.mem_wready = 1'b1;
        for (int j = 0; j < 12; j++) begin
            store((j == 0) ? 32'h40 : 32'h100 + 32'(4 * j), 32'h11 + 32'(j), 1'b1);
            #1;
            chk("lap_stall", {31'b0, core_if.stall}, 32'd0);
            step();
            chk("lap_not_empty", {31'b0, empty}, 32'd0);
        end
        core_if.memwrite  = 1'b0;
        mem_if.mem_wready = 1'b0;
        store(32'h200, 32'hBAD, 1'b0);
        #1;
        chk("lap_still_full", {31'b0, core_if.stall}, 32'd1);
        core_if.memwrite = 1'b0;
        core_if.memread  = 1'b1;
        core_if.aluout   = 32'h128;
        #1;
        chk("lap_fwd", core_if.readdata, 32'h1B);
        core_if.aluout = 32'h104;
        #1;
        chk("lap_fwd_gone", core_if.readdata, 32'hAAAA5555);
        core_if.memread   = 1'b0;
        mem_if.mem_wready = 1'b1;
        repeat (6) step();
        chk("lap_drained", {31'b0, empty}, 32'd1);

        // Asynchronous reset while writes are pending
        mem_if.mem_wready = 1'b0;
        store(32'h300, 32'h1, 1'b0); step();
        store(32'h304, 32'h2, 1'b0); step();
        store(32'h308, 32'h3, 1'b0); step();
        core_if.memwrite = 1'b0;
        chk("pre_rst_wvalid", {31'b0, mem_if.mem_wvalid}, 32'd1);
        #3 reset = 1'b0;
        #1;
        chk("async_rst_wvalid", {31'b0, mem_if.mem_wvalid}, 32'd0);
        chk("async_rst_empty",  {31'b0, empty}, 32'd1);
        chk("async_rst_waddr",  mem_if.mem_waddr, 32'h0);
        repeat (3) step();
        #3 reset = 1'b1;
        mem_if.mem_wready = 1'b1;
        core_if.memread   = 1'b1;
        core_if.aluout    = 32'h304;
        #1;
        chk("post_rst_no_fwd", core_if.readdata, 32'hAAAA5555);
        core_if.memread = 1'b0;
        repeat (5) step();
        chk("post_rst_empty",  {31'b0, empty}, 32'd1);
        chk("post_rst_wvalid", {31'b0, mem_if.mem_wvalid}, 32'd0);

        step();
        chk("scoreboard_left", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
